// File: rtl/spi_flash_master_pkg.sv
// Shared definitions for the byte-wide SPI flash master: IO bit positions and FSM encoding.
package spi_flash_master_pkg;

    localparam int unsigned SPI_CTRL_BIT = 3;
    localparam int unsigned SPI_DATA_BIT = 10;
    localparam int unsigned SPI_STAT_BIT = 13;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLow  = 2'd1,
        StHigh = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_flash_master_if.sv
// CPU-side register interface of the SPI flash master (strobes in, status and data out).
interface spi_flash_master_if;

    logic       wr_data;
    logic       wr_ctrl;
    logic       rd_data;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       cs_active;

    modport master (
        output wr_data, wr_ctrl, rd_data, tx_data,
        input  rx_data, rx_valid, busy, cs_active
    );

    modport slave (
        input  wr_data, wr_ctrl, rd_data, tx_data,
        output rx_data, rx_valid, busy, cs_active
    );

endinterface

// File: rtl/spi_flash_master_clkgen.sv
// Half-period counter for the SPI master; emits one-cycle SCK rise/fall request pulses.
module spi_flash_master_clkgen #(
    parameter int unsigned HALF = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic sck,
    output logic rise,
    output logic fall
);

    logic [CNTW-1:0] div_q;
    logic            tick;

    assign tick = run && (div_q == CNTW'(HALF - 1));
    assign rise = tick && !sck;
    assign fall = tick && sck;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            div_q <= '0;
        end else if (run) begin
            div_q <= tick ? '0 : div_q + CNTW'(1);
        end
    end

endmodule

// File: rtl/spi_flash_master.sv
// Byte-wide SPI mode-0 master: one write starts a byte, software polls busy, CS is manual.
module spi_flash_master
    import spi_flash_master_pkg::*;
#(
    parameter int unsigned HALF = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_master_if.slave  bus,
    output logic               spi_sck,
    output logic               spi_mosi,
    input  logic               spi_miso,
    output logic               spi_cs_n
);

    spi_state_e state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       start;
    logic       rise;
    logic       fall;

    spi_flash_master_clkgen #(
        .HALF (HALF),
        .CNTW (CNTW)
    ) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .run   (state_q != StIdle),
        .sck   (sck_q),
        .rise  (rise),
        .fall  (fall)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        start      = 1'b0;

        // Completion below overrides a same-cycle read acknowledge.
        if (bus.rd_data) begin
            rx_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.wr_ctrl) begin
                    cs_n_d = ~bus.tx_data[0];
                end
                if (bus.wr_data) begin
                    start      = 1'b1;
                    shreg_d    = bus.tx_data;
                    mosi_d     = bus.tx_data[7];
                    bitcnt_d   = 3'd7;
                    rx_valid_d = 1'b0;
                    state_d    = StLow;
                end
            end
            StLow: begin
                if (rise) begin
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[6:0], spi_miso};
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (fall) begin
                    sck_d = 1'b0;
                    if (bitcnt_q == 3'd0) begin
                        rx_data_d  = shreg_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        mosi_d   = shreg_q[7];
                        bitcnt_d = bitcnt_q - 3'd1;
                        state_d  = StLow;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bitcnt_q   <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bitcnt_q   <= bitcnt_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign spi_sck       = sck_q;
    assign spi_mosi      = mosi_q;
    assign spi_cs_n      = cs_n_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.cs_active = ~cs_n_q;

endmodule

// File: doc/spi_flash_master.md
Name: spi_flash_master

Overview:
- Byte-wide SPI mode-0 master, mapped on the j1 IO bus at 0x0008 (misc.out) and 0x2000 (misc.in) in place of the bit-banged flash pins.
- Sits downstream of the registered IO decode: `io_wr_`, `io_rd_`, `io_addr_`, `dout_`. Drives flash SCK/MOSI/CS and samples MISO.
- Software starts a transfer with one write and polls `busy`. No per-bit Forth toggling.

Parameters:
- HALF, 2, SCK half-period in clk cycles (>=1); one byte takes 16*HALF cycles.
- CNTW, 8, width of the half-period counter; HALF must be < 2**CNTW.

Ports:
- clk  in  1  system clock (PLL global clock)
- reset  in  1  synchronous, active-high reset
- wr_data  in  1  one-cycle strobe: start a byte transfer with tx_data
- wr_ctrl  in  1  one-cycle strobe: load chip-select from tx_data[0]
- rd_data  in  1  one-cycle strobe: rx byte consumed, clears rx_valid
- tx_data  in  8  write data (`dout_[7:0]`)
- rx_data  out  8  last received byte
- rx_valid  out  1  a completed byte is unread
- busy  out  1  transfer in progress
- cs_active  out  1  readback of chip-select (1 = asserted)
- spi_sck  out  1  SPI clock, idles low
- spi_mosi  out  1  SPI data out, MSB first
- spi_miso  in  1  SPI data in, already registered once by the pad
- spi_cs_n  out  1  flash chip-select, active low

Behaviour:
- Reset values (synchronous, also mid-transfer): state IDLE, spi_sck 0, spi_mosi 0, spi_cs_n 1, cs_active 0, busy 0, rx_data 0x00, rx_valid 0, counters 0. An aborted byte is discarded.
- FSM states: IDLE, LOW, HIGH.
- IDLE, wr_data=1:
  - shreg <= tx_data; spi_mosi <= tx_data[7]; bitcnt <= 7; div <= 0.
  - busy <= 1; rx_valid <= 0; go to LOW.
- LOW:
  - div increments each cycle.
  - When div==HALF-1: spi_sck <= 1; shreg <= {shreg[6:0], spi_miso}; div <= 0; go to HIGH.
- HIGH:
  - div increments each cycle.
  - When div==HALF-1: spi_sck <= 0; div <= 0.
  - If bitcnt==0: rx_data <= shreg; rx_valid <= 1; busy <= 0; go to IDLE.
  - Else: spi_mosi <= shreg[7]; bitcnt <= bitcnt-1; go to LOW.
- Latency: busy rises on the edge after the wr_data cycle and falls exactly 16*HALF cycles later. rx_valid rises on that same edge.
- Bit timing:
  - MOSI changes only on SCK falling edges (or at load), so it is stable for HALF cycles before each rising edge.
  - MISO is sampled at each SCK rising edge.
- wr_data while busy: ignored; no state change and no error flag. Software must poll busy.
- wr_ctrl:
  - In IDLE: spi_cs_n <= ~tx_data[0]; cs_active <= tx_data[0].
  - While busy: ignored (CS never changes mid-byte).
- wr_data and wr_ctrl in the same IDLE cycle: both take effect. CS is applied on the same edge as the load, and the first SCK rise follows HALF cycles later.
- rd_data: rx_valid <= 0. If rd_data coincides with completion, completion wins and rx_valid = 1.
- rx_data holds its value until the next completion.
- CS is never toggled automatically. Multi-byte flash commands keep CS asserted across bytes.
- SCK is exactly 50% duty; the first rising edge is HALF cycles after the load edge.

Decomposition:
- Shared package: IO bit positions (SPI_CTRL_BIT=3, SPI_STAT_BIT=13, SPI_DATA_BIT=10) and the state encoding (IDLE=0, LOW=1, HIGH=2).
- The top decodes wr_data/wr_ctrl/rd_data from `io_wr_`/`io_rd_`/`io_addr_` and ORs {busy, rx_valid, cs_active} into the misc.in word.
- Natural sub-module: spi_clkgen (half-period counter emitting rise/fall pulses). Shift register and FSM stay in spi_flash_master.

Test Plan:
- Reset, then idle 20 cycles -> spi_cs_n=1, spi_sck=0, busy=0, rx_valid=0, rx_data=0x00.
- HALF=2, spi_miso looped to spi_mosi, wr_ctrl with tx_data=0x01 then wr_data 0xA5 -> cs_n=0; exactly 8 SCK rising edges; busy high 32 cycles; rx_data=0xA5, rx_valid=1.
- MISO driven by a model returning 0x3C, wr_data 0x9F (READ ID) -> MOSI bits 1,0,0,1,1,1,1,1 at the rising edges; rx_data=0x3C.
- wr_data 0x55 issued 5 cycles into a 0xA5 transfer, plus wr_ctrl with tx_data=0x00 mid-byte -> loopback result 0xA5; cs_n stays 0; total busy time still 32 cycles.
- reset asserted on cycle 10 of a transfer -> on the next edge sck=0, cs_n=1, busy=0, rx_valid=0. A subsequent 0x0F transfer completes normally with rx_data=0x0F.
- rd_data asserted on the completion cycle -> rx_valid=1. rd_data one cycle later -> rx_valid=0, rx_data unchanged.
